lsbx: RTL and testbench

Parametrised LED/switch/button controller, successor to the fixed 8-LED / 4-button / 4-switch LSB device. It sits on the processor I/O bus as a four-register device and provides:
- configurable channel counts and debounce interval;
- sticky button-press event latches with a maskable interrupt;
- optional hardware LED blinking.

---
 rtl/lsbx.sv | 178 +++++++++++++++++
 tb/tb_lsbx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsbx.sv
// lsbx -- parametrised LED / switch / button controller on a four-register
// single-cycle I/O bus.
//
// Register map (addr):
//   0 LED    r/w  [NUM_LEDS-1:0]  led_reg
//   1 STATUS r/o  [NUM_SWI-1:0] swi_out, [8+NUM_BTN-1:8] btn_out
//   2 EVENT  r/w1c [NUM_BTN-1:0]  sticky button-press latches
//   3 CTRL   r/w  [NUM_BTN-1:0] irq_mask, [16+NUM_LEDS-1:16] blink_mask (LSB_BLINK_EN)
//
// Optional feature macro: LSB_BLINK_EN -- hardware LED blink prescaler and
// blink_mask. Undefined: leds = led_reg, CTRL[31:16] reads 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stb, we, addr   bus strobe, write enable, register select
//   data_in         write data
//   data_out        read data, zero unless stb & ~we
//   ack             bus acknowledge (= stb)
//   btn_in, swi_in  raw asynchronous buttons / switches
//   leds            LED drive
//   btn_out,swi_out debounced buttons / switches
//   irq             level interrupt, |(evt & irq_mask), registered

// Per-input synchroniser + debouncer.
module lsbx_dbnc #(
    parameter int DBNC_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = (DBNC_CNT > 1) ? $clog2(DBNC_CNT) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement restarts the hold window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DBNC_CNT - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module lsbx #(
    parameter int NUM_LEDS  = 8,
    parameter int NUM_BTN   = 4,
    parameter int NUM_SWI   = 4,
    parameter int DBNC_CNT  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stb,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic                ack,
    input  logic [NUM_BTN-1:0]  btn_in,
    input  logic [NUM_SWI-1:0]  swi_in,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_BTN-1:0]  btn_out,
    output logic [NUM_SWI-1:0]  swi_out,
    output logic                irq
);
    logic                wr;
    logic [NUM_LEDS-1:0] led_reg;
    logic [NUM_BTN-1:0]  evt;
    logic [NUM_BTN-1:0]  irq_mask;
    logic [NUM_BTN-1:0]  btn_prev;
    logic [NUM_BTN-1:0]  evt_clr;

    // Only the implemented fields of data_in are consumed.
    logic unused_data;
    assign unused_data = ^data_in;

    assign ack = stb;
    assign wr  = stb & we;

    // Debouncer lanes
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            lsbx_dbnc #(.DBNC_CNT(DBNC_CNT)) u_dbnc (
                .clk(clk), .rst(rst), .din(btn_in[gi]), .dout(btn_out[gi]));
        end
        for (gi = 0; gi < NUM_SWI; gi++) begin : g_swi
            lsbx_dbnc #(.DBNC_CNT(DBNC_CNT)) u_dbnc (
                .clk(clk), .rst(rst), .din(swi_in[gi]), .dout(swi_out[gi]));
        end
    endgenerate

    assign evt_clr = (wr && addr == 2'd2) ? data_in[NUM_BTN-1:0] : '0;

    // Register file, event latches and irq. A rising btn_out edge sets its
    // event bit even when a clear for that bit lands in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg  <= '0;
            evt      <= '0;
            irq_mask <= '0;
            btn_prev <= '0;
            irq      <= 1'b0;
        end else begin
            btn_prev <= btn_out;
            evt      <= (evt & ~evt_clr) | (btn_out & ~btn_prev);
            irq      <= |(evt & irq_mask);
            if (wr && addr == 2'd0) led_reg  <= data_in[NUM_LEDS-1:0];
            if (wr && addr == 2'd3) irq_mask <= data_in[NUM_BTN-1:0];
        end
    end

`ifdef LSB_BLINK_EN
    localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]       pre;
    logic                phase;
    logic [NUM_LEDS-1:0] blink_mask;

    // phase starts low, so blinking LEDs start dark after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre        <= '0;
            phase      <= 1'b0;
            blink_mask <= '0;
        end else begin
            if (pre == PW'(BLINK_DIV - 1)) begin
                pre   <= '0;
                phase <= ~phase;
            end else begin
                pre <= pre + PW'(1);
            end
            if (wr && addr == 2'd3) blink_mask <= data_in[16 +: NUM_LEDS];
        end
    end

    assign leds = led_reg & (~blink_mask | {NUM_LEDS{phase}});
`else
    localparam int unused_blink_div = BLINK_DIV;
    assign leds = led_reg;
`endif

    // Read mux
    always_comb begin
        data_out = '0;
        if (stb && !we) begin
            case (addr)
                2'd0: data_out[NUM_LEDS-1:0] = led_reg;
                2'd1: begin
                    data_out[NUM_SWI-1:0]  = swi_out;
                    data_out[8 +: NUM_BTN] = btn_out;
                end
                2'd2: data_out[NUM_BTN-1:0] = evt;
                default: begin
                    data_out[NUM_BTN-1:0] = irq_mask;
`ifdef LSB_BLINK_EN
                    data_out[16 +: NUM_LEDS] = blink_mask;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsbx.sv
// tb_lsbx -- randomized + directed bench for lsbx with a behavioural model.
// Build with or without LSB_BLINK_EN; the model follows the same macro.
module tb_lsbx;
    localparam int NL = 8, NB = 4, NS = 4, DB = 4, BD = 4;

    logic          clk = 1'b0, rst = 1'b1, stb = 1'b0, we = 1'b0;
    logic [1:0]    addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          ack, irq;
    logic [NB-1:0] btn_in = '0, btn_out;
    logic [NS-1:0] swi_in = '0, swi_out;
    logic [NL-1:0] leds;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    lsbx #(.NUM_LEDS(NL), .NUM_BTN(NB), .NUM_SWI(NS), .DBNC_CNT(DB), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack), .btn_in(btn_in), .swi_in(swi_in),
        .leds(leds), .btn_out(btn_out), .swi_out(swi_out), .irq(irq));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw input seen two edges ago is the synchronised level; a new level is
    // accepted once it has disagreed with the accepted level for DB edges.
    logic [NB-1:0] b_d1, b_d2, b_st, b_prev;
    logic [NS-1:0] s_d1, s_d2, s_st;
    int            b_run[NB];
    int            s_run[NS];
    logic [NB-1:0] m_evt, m_mask;
    logic [NL-1:0] m_led, m_bmask;
    logic          m_irq;
    int            m_ticks;

    always @(posedge clk or posedge rst) begin : model
        logic [NB-1:0] bst, clr;
        logic [NS-1:0] sst;
        int br[NB];
        int sr[NS];
        if (rst) begin
            b_d1 <= '0; b_d2 <= '0; b_st <= '0; b_prev <= '0;
            s_d1 <= '0; s_d2 <= '0; s_st <= '0;
            b_run <= '{default: 0}; s_run <= '{default: 0};
            m_evt <= '0; m_mask <= '0; m_led <= '0; m_bmask <= '0;
            m_irq <= 1'b0; m_ticks <= 0;
        end else begin
            bst = b_st; br = b_run; sst = s_st; sr = s_run;
            for (int i = 0; i < NB; i++) begin
                if (b_d2[i] != bst[i]) begin
                    br[i]++;
                    if (br[i] == DB) begin bst[i] = b_d2[i]; br[i] = 0; end
                end else br[i] = 0;
            end
            for (int i = 0; i < NS; i++) begin
                if (s_d2[i] != sst[i]) begin
                    sr[i]++;
                    if (sr[i] == DB) begin sst[i] = s_d2[i]; sr[i] = 0; end
                end else sr[i] = 0;
            end
            clr = (stb && we && addr == 2'd2) ? data_in[NB-1:0] : '0;
            m_irq  <= |(m_evt & m_mask);
            m_evt  <= (m_evt & ~clr) | (b_st & ~b_prev);
            b_prev <= b_st;
            b_st <= bst; b_run <= br; b_d2 <= b_d1; b_d1 <= btn_in;
            s_st <= sst; s_run <= sr; s_d2 <= s_d1; s_d1 <= swi_in;
            if (stb && we && addr == 2'd0) m_led <= data_in[NL-1:0];
            if (stb && we && addr == 2'd3) begin
                m_mask  <= data_in[NB-1:0];
                m_bmask <= data_in[16 +: NL];
            end
            m_ticks <= m_ticks + 1;
        end
    end

    // Compare process: outputs checked every cycle, away from the clock edge.
    always @(negedge clk) begin : compare
        logic [NL-1:0] el;
        logic [31:0]   ed;
        el = m_led;
`ifdef LSB_BLINK_EN
        if (((m_ticks / BD) % 2) == 0) el = m_led & ~m_bmask;
`endif
        ed = '0;
        if (stb && !we) begin
            case (addr)
                2'd0: ed = 32'(m_led);
                2'd1: ed = {20'b0, b_st, 4'b0, s_st};
                2'd2: ed = 32'(m_evt);
                default: begin
                    ed = 32'(m_mask);
`ifdef LSB_BLINK_EN
                    ed[16 +: NL] = m_bmask;
`endif
                end
            endcase
        end
        chk("leds", 32'(leds), 32'(el));
        chk("btn_out", 32'(btn_out), 32'(b_st));
        chk("swi_out", 32'(swi_out), 32'(s_st));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("data_out", data_out, ed);
        chk("ack", 32'(ack), 32'(stb));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        stb = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick(1);
        stb = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        stb = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(nm, data_out, e);
        chk({nm, "_ack"}, 32'(ack), 32'd1);
        tick(1);
        stb = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k, n_f0, n_ff, idx;
        #3;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        #9 rst = 1'b0;
        tick(1);

        // LED write / read, ack follows stb
        wr(2'd0, 32'hFFFF_FF5A);
        chk("led_write", 32'(leds), 32'h5A);
        rd(2'd0, 32'h0000_005A, "led_read");
        #1;
        chk("ack_idle", 32'(ack), 32'h0);

        // Switch glitch of 3 cycles must not pass
        swi_in[2] = 1'b1; tick(3); swi_in[2] = 1'b0;
        tick(10);
        chk("swi_glitch", 32'(swi_out), 32'h0);
        // Steady switch: appears exactly 6 cycles after the rise
        swi_in[2] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick(1);
            chk("swi_latency", 32'(swi_out), (c == 6) ? 32'h4 : 32'h0);
        end
        rd(2'd1, 32'h0000_0004, "status_read");

        // Button press with irq_mask=2
        wr(2'd3, 32'h2);
        btn_in[1] = 1'b1;
        for (k = 0; k < 20 && !btn_out[1]; k++) tick(1);
        chk("btn1_rise_wait", 32'(btn_out[1]), 32'h1);
        tick(2);
        rd(2'd2, 32'h2, "evt_set");
        chk("irq_set", 32'(irq), 32'h1);
        wr(2'd2, 32'h2);
        tick(1);
        chk("irq_clr", 32'(irq), 32'h0);
        rd(2'd2, 32'h0, "evt_clr");

        // Clear coinciding with a new rising edge: set wins
        btn_in[1] = 1'b0;
        for (k = 0; k < 20 && btn_out[1]; k++) tick(1);
        chk("btn1_fall_wait", 32'(btn_out[1]), 32'h0);
        tick(2);
        btn_in[1] = 1'b1;
        for (k = 0; k < 20 && !btn_out[1]; k++) tick(1);
        chk("btn1_rise_wait2", 32'(btn_out[1]), 32'h1);
        wr(2'd2, 32'h2);
        rd(2'd2, 32'h2, "evt_set_wins");

        // Mask gating
        wr(2'd3, 32'h0);
        btn_in = 4'hF;
        tick(12);
        rd(2'd2, 32'hF, "evt_all");
        chk("irq_masked", 32'(irq), 32'h0);
        wr(2'd3, 32'h8);
        chk("irq_mask_edge", 32'(irq), 32'h0);
        tick(1);
        chk("irq_unmasked", 32'(irq), 32'h1);

        // Blink
        wr(2'd0, 32'hFF);
        wr(2'd3, 32'h000F_0008);
        n_f0 = 0; n_ff = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (leds == 8'hF0) n_f0++;
            else if (leds == 8'hFF) n_ff++;
        end
`ifdef LSB_BLINK_EN
        chk("blink_dark", 32'(n_f0), 32'd4);
        chk("blink_lit", 32'(n_ff), 32'd4);
        rd(2'd3, 32'h000F_0008, "ctrl_read");
`else
        chk("noblink_dark", 32'(n_f0), 32'd0);
        chk("noblink_lit", 32'(n_ff), 32'd8);
        rd(2'd3, 32'h0000_0008, "ctrl_read");
`endif

        // Asynchronous reset mid-debounce
        wr(2'd0, 32'h5A);
        swi_in = 4'h1;
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_leds", 32'(leds), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_btn", 32'(btn_out), 32'h0);
        chk("arst_swi", 32'(swi_out), 32'h0);
        chk("arst_data", data_out, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(5) == 0) begin
                idx = $urandom_range(NB - 1);
                btn_in[idx] = ~btn_in[idx];
            end
            if ($urandom_range(5) == 0) begin
                idx = $urandom_range(NS - 1);
                swi_in[idx] = ~swi_in[idx];
            end
            stb = ($urandom_range(2) == 0);
            we = 1'($urandom_range(1));
            addr = 2'($urandom_range(3));
            data_in = $urandom();
            if (c == 700) begin #2 rst = 1'b1; end
            if (c == 702) rst = 1'b0;
            tick(1);
        end
        stb = 1'b0; we = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
